// File: rtl/cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cmp_pkg
// Purpose : Shared types and constants for the magnitude comparator and its
//           built-in self-test driver (FSM states, one-hot result codes).
// Revision: 1.0 - initial release
// ============================================================================
package cmp_pkg;

  // Sweep controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // One-hot comparator result, bit order {A>B, A==B, A<B} = {o3, o2, o1}
  localparam logic [2:0] CMP_LT = 3'b001;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b100;

endpackage
`default_nettype wire

// File: rtl/cmp_ref_model.sv
`default_nettype none
// ============================================================================
// Module  : cmp_ref_model
// Purpose : Combinational WIDTH-bit unsigned reference comparator producing
//           the one-hot {gt, eq, lt} result the DUT is expected to return.
// Revision: 1.0 - initial release
// ============================================================================
module cmp_ref_model
  import cmp_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       result
);

  // Unsigned magnitude compare mapped onto the one-hot result codes
  always_comb begin
    result = CMP_EQ;
    if (a < b) begin
      result = CMP_LT;
    end else if (a > b) begin
      result = CMP_GT;
    end
  end

endmodule
`default_nettype wire

// File: rtl/comparator_bist.sv
`default_nettype none
// ============================================================================
// Module  : comparator_bist
// Purpose : Exhaustive stimulus/checker for a WIDTH-bit magnitude comparator.
//           Sweeps every {A,B} pair, holds each for SETTLE_CYCLES, samples
//           o1/o2/o3 in a single CHECK cycle, and reports pass, an error
//           count and the first failing vector.
// Revision: 1.0 - initial release
// ============================================================================
module comparator_bist
  import cmp_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               o1_in,
  input  logic               o2_in,
  input  logic               o3_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int VEC_W = 2 * WIDTH;
  localparam int ERR_W = 2 * WIDTH + 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t             state, state_nxt;
  logic [VEC_W-1:0]   vec, vec_nxt;
  logic [CNT_W-1:0]   settle_cnt, settle_cnt_nxt;
  logic [ERR_W-1:0]   err_nxt;
  logic [WIDTH-1:0]   fail_a_nxt, fail_b_nxt;
  logic [2:0]         expected;
  logic               mismatch;

  // The vector counter is the operand register: {A,B} go straight to the DUT
  assign a_out = vec[VEC_W-1:WIDTH];
  assign b_out = vec[WIDTH-1:0];

  cmp_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .a      (a_out),
    .b      (b_out),
    .result (expected)
  );

  // Any deviation from the one-hot expectation (incl. multi-hot / all-zero)
  assign mismatch = ({o3_in, o2_in, o1_in} != expected);

  // Next-state and datapath update for the sweep controller
  always_comb begin
    state_nxt      = state;
    vec_nxt        = vec;
    settle_cnt_nxt = settle_cnt;
    err_nxt        = err_count;
    fail_a_nxt     = fail_a;
    fail_b_nxt     = fail_b;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = SETTLE;
          vec_nxt        = '0;
          settle_cnt_nxt = '0;
          err_nxt        = '0;
          fail_a_nxt     = '0;
          fail_b_nxt     = '0;
        end
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt      = CHECK;
          settle_cnt_nxt = '0;
        end else begin
          settle_cnt_nxt = settle_cnt + CNT_W'(1);
        end
      end
      CHECK: begin
        if (mismatch) begin
          // At most 2^(2*WIDTH) errors fit in ERR_W bits, so no wrap occurs
          err_nxt = err_count + ERR_W'(1);
          if (err_count == '0) begin
            fail_a_nxt = a_out;
            fail_b_nxt = b_out;
          end
        end
        if (&vec) begin
          state_nxt = DONE;
        end else begin
          vec_nxt   = vec + VEC_W'(1);
          state_nxt = SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; status flags derive from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_a     <= '0;
      fail_b     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      state      <= state_nxt;
      vec        <= vec_nxt;
      settle_cnt <= settle_cnt_nxt;
      err_count  <= err_nxt;
      fail_a     <= fail_a_nxt;
      fail_b     <= fail_b_nxt;
      busy       <= (state_nxt == SETTLE) || (state_nxt == CHECK);
      done       <= (state_nxt == DONE);
      pass       <= (state_nxt == DONE) && (err_nxt == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_comparator_bist.sv
`default_nettype none
// ============================================================================
// Module  : tb_comparator_bist
// Purpose : Self-checking bench for comparator_bist. A behavioural comparator
//           response table (correct, faulty or random) feeds two instances
//           (WIDTH=1/SETTLE=2 and WIDTH=4/SETTLE=1); expected results come
//           from an arithmetic sweep over the same table.
// Revision: 1.0 - initial release
// ============================================================================
module tb_comparator_bist;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  int         sel;
  int         total = 0;
  int         bad   = 0;

  // Comparator response per {A,B} index, shared by both instances
  logic [2:0] resp [256];

  // Instance 1: WIDTH=1, SETTLE_CYCLES=2
  logic       start1, a1, b1, o1_1, o2_1, o3_1, busy1, done1, pass1, fa1, fb1;
  logic [2:0] err1;
  // Instance 2: WIDTH=4, SETTLE_CYCLES=1
  logic       start2, o1_2, o2_2, o3_2, busy2, done2, pass2;
  logic [3:0] a2, b2, fa2, fb2;
  logic [8:0] err2;

  logic [7:0] idx1, idx2;
  logic [7:0] obs_vec, obs_fa, obs_fb;
  logic [15:0] obs_err;
  logic       obs_busy, obs_done, obs_pass;

  always #5 clk = ~clk;

  assign start1 = start && (sel == 0);
  assign start2 = start && (sel == 1);
  assign idx1   = {6'd0, a1, b1};
  assign idx2   = {a2, b2};
  assign {o3_1, o2_1, o1_1} = resp[idx1];
  assign {o3_2, o2_2, o1_2} = resp[idx2];

  comparator_bist #(.WIDTH(1), .SETTLE_CYCLES(2)) u_bist1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
    .o1_in(o1_1), .o2_in(o2_1), .o3_in(o3_1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_a(fa1), .fail_b(fb1)
  );

  comparator_bist #(.WIDTH(4), .SETTLE_CYCLES(1)) u_bist4 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
    .o1_in(o1_2), .o2_in(o2_2), .o3_in(o3_2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .fail_a(fa2), .fail_b(fb2)
  );

  // Observe whichever instance is currently selected
  always_comb begin
    obs_vec  = {6'd0, a1, b1};
    obs_fa   = {7'd0, fa1};
    obs_fb   = {7'd0, fb1};
    obs_err  = {13'd0, err1};
    obs_busy = busy1;
    obs_done = done1;
    obs_pass = pass1;
    if (sel == 1) begin
      obs_vec  = {a2, b2};
      obs_fa   = {4'd0, fa2};
      obs_fb   = {4'd0, fb2};
      obs_err  = {7'd0, err2};
      obs_busy = busy2;
      obs_done = done2;
      obs_pass = pass2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ideal one-hot answer for index v of a width-w sweep
  function automatic logic [2:0] ideal(input int w, input int v);
    int a, b;
    a = v >> w;
    b = v & ((1 << w) - 1);
    if (a < b) return 3'b001;
    if (a == b) return 3'b010;
    return 3'b100;
  endfunction

  // mode 0: correct, 1: o2 stuck-at-0, 2: o1=o3=1 always, 3: random corruption
  task automatic fill(input int w, input int mode);
    for (int v = 0; v < (1 << (2 * w)); v++) begin
      case (mode)
        0: resp[v] = ideal(w, v);
        1: resp[v] = ideal(w, v) & 3'b101;
        2: resp[v] = 3'b101;
        default: resp[v] = ($urandom_range(0, 1) == 1) ? ideal(w, v) : 3'($urandom);
      endcase
    end
  endtask

  // Reference: count vectors whose response differs from the ideal one-hot
  task automatic model(input int w, output int errs, output int fa, output int fb);
    errs = 0; fa = 0; fb = 0;
    for (int v = 0; v < (1 << (2 * w)); v++) begin
      if (resp[v] !== ideal(w, v)) begin
        if (errs == 0) begin
          fa = v >> w;
          fb = v & ((1 << w) - 1);
        end
        errs++;
      end
    end
  endtask

  // One full sweep on instance s_sel; optional extra start pulse at cycle extra_at
  task automatic run(input int s_sel, input int extra_at);
    int w, s, t, ee, efa, efb;
    w = (s_sel == 1) ? 4 : 1;
    s = (s_sel == 1) ? 1 : 2;
    t = (s + 1) * (1 << (2 * w));
    model(w, ee, efa, efb);
    sel = s_sel;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_clear", {obs_busy, obs_done, obs_pass, obs_err, obs_fa, obs_fb},
          {1'b1, 1'b0, 1'b0, 16'd0, 8'd0, 8'd0});
    for (int e = 0; e < t; e++) begin
      if (e > 0) begin
        @(posedge clk); #1;
      end
      check("sweep_busy_done_vec", {22'd0, obs_busy, obs_done, obs_vec},
            {22'd0, 1'b1, 1'b0, 8'(e / (s + 1))});
      start = (e == extra_at);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("done_flags", {obs_busy, obs_done, obs_pass}, {1'b0, 1'b1, (ee == 0)});
    check("err_count", obs_err, ee);
    check("fail_a", obs_fa, efa);
    check("fail_b", obs_fb, efb);
    repeat (3) @(posedge clk);
    #1;
    check("done_held", {obs_busy, obs_done, obs_pass, obs_err}, {1'b0, 1'b1, (ee == 0), 16'(ee)});
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 0;
    fill(1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_w1", {busy1, done1, pass1, err1, a1, b1, fa1, fb1}, 32'd0);
    check("reset_w4", {busy2, done2, pass2, err2, a2, b2, fa2, fb2}, 32'd0);
    rst_n = 1'b1;

    run(0, -1);              // correct DUT
    fill(1, 1); run(0, -1);  // o2 stuck-at-0
    fill(1, 2); run(0, -1);  // multi-hot
    fill(1, 0); run(0, 4);   // restart from DONE, ignored start while busy
    repeat (3) begin
      fill(1, 3); run(0, -1);
    end

    // Reset mid-sweep
    fill(1, 3);
    sel = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_reset", {busy1, done1, pass1, err1, a1, b1, fa1, fb1}, 32'd0);
    rst_n = 1'b1;
    fill(1, 0); run(0, -1);

    // Wide instance
    fill(4, 0); run(1, -1);
    fill(4, 3); run(1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
